decode_issue_sequencer: RTL and testbench

DECODE_ISSUE_SEQUENCER -- requirements
Module: decode_issue_sequencer

---
 rtl/decode_issue_pkg.sv | 23 ++
 rtl/decode_issue_fifo.sv | 57 +++++
 rtl/decode_issue_sequencer.sv | 134 +++++++++++++
 tb/tb_decode_issue_sequencer.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/decode_issue_pkg.sv
// Shared types and defaults for the decode issue sequencer.
// Holds issue modes, FSM states and parameter defaults.
package decode_issue_pkg;

  typedef enum logic {
    ISSUE_BURST,
    ISSUE_GAP
  } issue_mode_e;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    GAP,
    HOLD
  } issue_state_e;

  localparam int          DEF_DATA_W        = 16;
  localparam int          DEF_DEPTH         = 8;
  localparam int          DEF_HOLD_CYCLES   = 1;
  localparam int          DEF_STALL_TIMEOUT = 64;
  localparam issue_mode_e DEF_MODE          = ISSUE_BURST;

endpackage

// File: rtl/decode_issue_fifo.sv
// Circular queue of W-bit entries with full/empty/count.
// Ports: clock, reset, push/wdata, pop/rdata, full, empty, count.
module decode_issue_fifo #(
  parameter int W     = 32,
  parameter int DEPTH = 8
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     push,
  input  logic [W-1:0]             wdata,
  input  logic                     pop,
  output logic [W-1:0]             rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rptr];

  always_ff @(posedge clock) begin
    if (do_push && !reset)
      mem[wptr] <= wdata;
  end

  // DEPTH is a power of two, so pointers wrap by overflow.
  always_ff @(posedge clock) begin
    if (reset) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push)
        wptr <= wptr + AW'(1);
      if (do_pop)
        rptr <= rptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/decode_issue_sequencer.sv
// Queues instruction/NPC pairs and issues them to decode.
// Ports: push handshake, stall, dout/npc_in/enable_decode, count, stall_err.
module decode_issue_sequencer
  import decode_issue_pkg::*;
#(
  parameter int          DATA_W        = DEF_DATA_W,
  parameter int          DEPTH         = DEF_DEPTH,
  parameter int          HOLD_CYCLES   = DEF_HOLD_CYCLES,
  parameter int          STALL_TIMEOUT = DEF_STALL_TIMEOUT,
  parameter issue_mode_e MODE          = DEF_MODE
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     push_valid,
  output logic                     push_ready,
  input  logic [DATA_W-1:0]        push_instr,
  input  logic [DATA_W-1:0]        push_npc,
  input  logic                     stall,
  output logic [DATA_W-1:0]        dout,
  output logic [DATA_W-1:0]        npc_in,
  output logic                     enable_decode,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     stall_err
);

  localparam int HW = $clog2(HOLD_CYCLES + 2);
  localparam int SW = $clog2(STALL_TIMEOUT + 1);

  issue_state_e      state;
  logic [HW-1:0]     holdcnt;
  logic [SW-1:0]     stall_cnt;
  logic [SW-1:0]     stall_nxt;
  logic [2*DATA_W-1:0] head;
  logic              fifo_full;
  logic              fifo_empty;
  logic              push;
  logic              pop;
  logic              can_pop;

  assign push_ready = !fifo_full;
  assign push       = push_valid && push_ready;

  decode_issue_fifo #(
    .W     (2 * DATA_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clock (clock),
    .reset (reset),
    .push  (push),
    .wdata ({push_instr, push_npc}),
    .pop   (pop),
    .rdata (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (count)
  );

  // GAP is the bubble itself; the entry after it may pop at its end.
  always_comb begin
    can_pop = 1'b0;
    case (state)
      IDLE, GAP, HOLD: can_pop = 1'b1;
      ISSUE:           can_pop = (MODE == ISSUE_BURST);
      default:         can_pop = 1'b0;
    endcase
  end

  assign pop = can_pop && !fifo_empty && !stall;

  always_ff @(posedge clock) begin
    if (reset) begin
      state         <= IDLE;
      holdcnt       <= '0;
      dout          <= '0;
      npc_in        <= '0;
      enable_decode <= 1'b0;
    end else if (!stall) begin
      if (pop) begin
        dout          <= head[2*DATA_W-1:DATA_W];
        npc_in        <= head[DATA_W-1:0];
        enable_decode <= 1'b1;
        holdcnt       <= '0;
        state         <= ISSUE;
      end else begin
        case (state)
          ISSUE: begin
            if (MODE == ISSUE_GAP) begin
              state         <= GAP;
              enable_decode <= 1'b0;
            end else if (HOLD_CYCLES == 0) begin
              state         <= IDLE;
              enable_decode <= 1'b0;
            end else begin
              state   <= HOLD;
              holdcnt <= HW'(HOLD_CYCLES);
            end
          end
          GAP: begin
            state         <= IDLE;
            enable_decode <= 1'b0;
          end
          HOLD: begin
            holdcnt <= holdcnt - HW'(1);
            if (holdcnt <= HW'(1)) begin
              state         <= IDLE;
              enable_decode <= 1'b0;
            end
          end
          default: enable_decode <= 1'b0;
        endcase
      end
    end
  end

  // Saturating watchdog; the error latches on the edge the count hits the limit.
  always_comb begin
    stall_nxt = '0;
    if (stall)
      stall_nxt = (stall_cnt == SW'(STALL_TIMEOUT)) ?
                  stall_cnt : stall_cnt + SW'(1);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      stall_cnt <= '0;
      stall_err <= 1'b0;
    end else begin
      stall_cnt <= stall_nxt;
      if (stall_nxt == SW'(STALL_TIMEOUT))
        stall_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_decode_issue_sequencer.sv
// Directed bench with scoreboards for burst and gap instances.
// Issues are detected by a new dout/npc pair while enable_decode is high.
module tb_decode_issue_sequencer;
  import decode_issue_pkg::*;

  logic        clock = 1'b0;
  logic        reset;
  logic        stall;
  logic        push_valid;
  logic        g_valid;
  logic [15:0] push_instr;
  logic [15:0] push_npc;

  logic        m_ready, g_ready;
  logic [15:0] m_dout, g_dout, m_npc, g_npc;
  logic        m_en, g_en, m_err, g_err;
  logic [3:0]  m_count, g_count;

  logic [31:0] m_q[$];
  logic [31:0] g_q[$];
  logic [31:0] m_last = '0;
  logic [31:0] g_last = '0;
  logic [19:0] rec;
  logic [19:0] want;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clock = ~clock;

  decode_issue_sequencer #(
    .DATA_W(16), .DEPTH(8), .HOLD_CYCLES(1),
    .STALL_TIMEOUT(64), .MODE(ISSUE_BURST)
  ) u_burst (
    .clock(clock), .reset(reset),
    .push_valid(push_valid), .push_ready(m_ready),
    .push_instr(push_instr), .push_npc(push_npc),
    .stall(stall), .dout(m_dout), .npc_in(m_npc),
    .enable_decode(m_en), .count(m_count),
    .stall_err(m_err)
  );

  decode_issue_sequencer #(
    .DATA_W(16), .DEPTH(8), .HOLD_CYCLES(1),
    .STALL_TIMEOUT(64), .MODE(ISSUE_GAP)
  ) u_gap (
    .clock(clock), .reset(reset),
    .push_valid(g_valid), .push_ready(g_ready),
    .push_instr(push_instr), .push_npc(push_npc),
    .stall(stall), .dout(g_dout), .npc_in(g_npc),
    .enable_decode(g_en), .count(g_count),
    .stall_err(g_err)
  );

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h",
                tag, obs, exp);
  endtask

  task automatic push(input bit g,
                      input logic [15:0] i,
                      input logic [15:0] n);
    logic ok;
    push_instr = i;
    push_npc   = n;
    if (g) begin
      g_valid = 1'b1;
      ok = g_ready;
    end else begin
      push_valid = 1'b1;
      ok = m_ready;
    end
    @(posedge clock);
    if (ok) begin
      if (g) g_q.push_back({i, n});
      else   m_q.push_back({i, n});
    end
    #1;
    push_valid = 1'b0;
    g_valid    = 1'b0;
  endtask

  always @(negedge clock) begin
    if (reset) begin
      m_last = '0;
    end else if (m_en && {m_dout, m_npc} != m_last) begin
      m_last = {m_dout, m_npc};
      if (m_q.size() == 0) begin
        n_chk++;
        $error("FAIL m_issue observed=%0h expected=none", m_last);
      end else begin
        check("m_issue", m_last, m_q.pop_front());
      end
    end
  end

  always @(negedge clock) begin
    if (reset) begin
      g_last = '0;
    end else if (g_en && {g_dout, g_npc} != g_last) begin
      g_last = {g_dout, g_npc};
      if (g_q.size() == 0) begin
        n_chk++;
        $error("FAIL g_issue observed=%0h expected=none", g_last);
      end else begin
        check("g_issue", g_last, g_q.pop_front());
      end
    end
  end

  initial begin
    reset      = 1'b1;
    stall      = 1'b0;
    push_valid = 1'b0;
    g_valid    = 1'b0;
    push_instr = '0;
    push_npc   = '0;
    repeat (2) @(posedge clock);
    #1;
    check("rst_count", 32'(m_count), 0);
    check("rst_ready", 32'(m_ready), 1);
    check("rst_dout", 32'(m_dout), 0);
    check("rst_npc", 32'(m_npc), 0);
    check("rst_en", 32'(m_en), 0);
    check("rst_err", 32'(m_err), 0);
    check("rst_g_en", 32'(g_en), 0);
    reset = 1'b0;

    // single push, then one hold cycle
    push(0, 16'h1234, 16'h3001);
    check("single_count", 32'(m_count), 1);
    @(posedge clock); #1;
    check("single_en1", 32'(m_en), 1);
    check("single_dout", 32'(m_dout), 32'h1234);
    check("single_npc", 32'(m_npc), 32'h3001);
    @(posedge clock); #1;
    check("single_en2", 32'(m_en), 1);
    @(posedge clock); #1;
    check("single_en3", 32'(m_en), 0);
    check("single_empty", 32'(m_count), 0);

    // burst mode: 8 issues plus one hold cycle
    fork
      begin
        for (int i = 0; i < 8; i++)
          push(0, 16'h1100 + 16'(i), 16'h2200 + 16'(i));
      end
      begin
        for (int k = 0; k < 20; k++) begin
          @(posedge clock); #1;
          rec[k] = m_en;
        end
      end
    join
    want = '0;
    for (int k = 1; k <= 9; k++) want[k] = 1'b1;
    check("burst_en", 32'(rec), 32'(want));
    check("burst_sb", 32'(m_q.size()), 0);

    // gap mode: issue every other cycle
    fork
      begin
        for (int i = 0; i < 8; i++)
          push(1, 16'h3300 + 16'(i), 16'h4400 + 16'(i));
      end
      begin
        for (int k = 0; k < 20; k++) begin
          @(posedge clock); #1;
          rec[k] = g_en;
        end
      end
    join
    want = '0;
    for (int k = 1; k <= 15; k += 2) want[k] = 1'b1;
    check("gap_en", 32'(rec), 32'(want));
    check("gap_sb", 32'(g_q.size()), 0);

    // fill under stall, refuse the ninth, then drain
    stall = 1'b1;
    for (int i = 0; i < 8; i++)
      push(0, 16'h5500 + 16'(i), 16'h6600 + 16'(i));
    check("fill_count", 32'(m_count), 8);
    check("fill_ready", 32'(m_ready), 0);
    check("fill_dout_hold", 32'(m_dout), 32'h1107);
    push(0, 16'h55ff, 16'h66ff);
    check("fill_refused", 32'(m_count), 8);
    check("fill_sb", 32'(m_q.size()), 8);
    stall = 1'b0;
    repeat (12) @(posedge clock);
    #1;
    check("drain_count", 32'(m_count), 0);
    check("drain_sb", 32'(m_q.size()), 0);

    // stall watchdog
    stall = 1'b1;
    repeat (63) @(posedge clock);
    #1;
    check("wd_63", 32'(m_err), 0);
    @(posedge clock); #1;
    check("wd_64", 32'(m_err), 1);
    stall = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    check("wd_sticky", 32'(m_err), 1);
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    check("wd_reset", 32'(m_err), 0);

    // reset mid-burst with a coincident push
    push(0, 16'h7000, 16'h7001);
    @(posedge clock); #1;
    stall = 1'b1;
    for (int i = 0; i < 5; i++)
      push(0, 16'h7700 + 16'(i), 16'h8800 + 16'(i));
    check("mid_count", 32'(m_count), 5);
    check("mid_en_hold", 32'(m_en), 1);
    check("mid_dout_hold", 32'(m_dout), 32'h7000);
    reset      = 1'b1;
    push_valid = 1'b1;
    push_instr = 16'h9999;
    push_npc   = 16'h9999;
    m_q.delete();
    @(posedge clock); #1;
    push_valid = 1'b0;
    reset      = 1'b0;
    stall      = 1'b0;
    check("mid_rst_count", 32'(m_count), 0);
    check("mid_rst_en", 32'(m_en), 0);
    check("mid_rst_dout", 32'(m_dout), 0);
    @(posedge clock); #1;
    check("mid_drop", 32'(m_count), 0);
    push(0, 16'habcd, 16'h4321);
    @(posedge clock); #1;
    check("post_en", 32'(m_en), 1);
    check("post_dout", 32'(m_dout), 32'habcd);
    repeat (3) @(posedge clock);
    #1;
    check("post_sb", 32'(m_q.size()), 0);
    check("post_en_off", 32'(m_en), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
